// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic             SUB;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] S;
  logic             COUT;
  logic             OVF;

  modport master (
    output START, SUB, A, B,
    input  BUSY, DONE, S, COUT, OVF
  );

  modport slave (
    input  START, SUB, A, B,
    output BUSY, DONE, S, COUT, OVF
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor, one operand bit per clock,
// wrapped in a START/BUSY/DONE handshake with held result registers.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input logic           C,
  input logic           R,
  serial_addsub_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             cin;
  logic             last;
  logic             p;
  logic             g;
  logic             sum_bit;
  logic             carry;

  assign last = (cnt == CW'(WIDTH - 1));

  // Single-bit propagate/generate carry cell.
  always_comb begin
    p       = opa[0] ^ opb[0];
    g       = opa[0] & opb[0];
    sum_bit = p ^ cin;
    carry   = p ? cin : g;
  end

  always_ff @(posedge C) begin
    if (R) state <= IDLE;
    else   state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.START) state_nx = RUN;
      RUN:     if (last) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.BUSY = (state == RUN);
    bus.DONE = (state == FIN);
  end

  always_ff @(posedge C) begin
    if (R) begin
      opa      <= '0;
      opb      <= '0;
      res      <= '0;
      cin      <= 1'b0;
      cnt      <= '0;
      bus.S    <= '0;
      bus.COUT <= 1'b0;
      bus.OVF  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.START) begin
            opa <= bus.A;
            opb <= bus.SUB ? ~bus.B : bus.B;
            cin <= bus.SUB;
            cnt <= '0;
          end
        end
        RUN: begin
          res <= {sum_bit, res[WIDTH-1:1]};
          opa <= {1'b0, opa[WIDTH-1:1]};
          opb <= {1'b0, opb[WIDTH-1:1]};
          cin <= carry;
          cnt <= cnt + 1'b1;
          // On the MSB, cin is the carry into the MSB, so overflow needs no extra register.
          if (last) begin
            bus.S    <= {sum_bit, res[WIDTH-1:1]};
            bus.COUT <= carry;
            bus.OVF  <= cin ^ carry;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub at WIDTH=8.
module tb_serial_addsub;
  localparam int WIDTH = 8;

  logic C;
  logic R;
  int   vectors;
  int   miscompares;

  serial_addsub_if #(.WIDTH(WIDTH)) bus ();

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .C   (C),
    .R   (R),
    .bus (bus)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  // Presents a request and returns 1 time unit after the sampling edge (edge 0).
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic sub);
    @(negedge C);
    bus.START = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.SUB   = sub;
    tick();
    bus.START = 1'b0;
  endtask

  task automatic test_reset();
    R         = 1'b1;
    bus.START = 1'b0;
    bus.SUB   = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    tick();
    tick();
    vectors++;
    if ({bus.BUSY, bus.DONE, bus.S, bus.COUT, bus.OVF} !== 11'h000) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b s=%h cout=%b ovf=%b, want all 0",
               bus.BUSY, bus.DONE, bus.S, bus.COUT, bus.OVF);
    end
    R = 1'b0;
    tick();
    vectors++;
    if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", bus.BUSY, bus.DONE);
    end
  endtask

  task automatic test_arith();
    logic [7:0] ta [5] = '{8'h3C, 8'hFF, 8'h7F, 8'h05, 8'h80};
    logic [7:0] tb [5] = '{8'h05, 8'h01, 8'h01, 8'h07, 8'h01};
    logic       tsub [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] ts [5] = '{8'h41, 8'h00, 8'h80, 8'hFE, 8'h7F};
    logic       tc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       tv [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] prev_s = 8'h00;
    for (int k = 0; k < 5; k++) begin
      launch(ta[k], tb[k], tsub[k]);
      for (int i = 0; i < WIDTH; i++) begin
        vectors++;
        if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0 || bus.S !== prev_s) begin
          miscompares++;
          $display("FAIL arith%0d_run_cycle%0d: got busy=%b done=%b s=%h, want 1 0 %h",
                   k, i, bus.BUSY, bus.DONE, bus.S, prev_s);
        end
        if (i < WIDTH - 1) tick();
      end
      tick();
      vectors++;
      if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b1 || bus.S !== ts[k] ||
          bus.COUT !== tc[k] || bus.OVF !== tv[k]) begin
        miscompares++;
        $display("FAIL arith%0d_result: got busy=%b done=%b s=%h cout=%b ovf=%b, want 0 1 %h %b %b",
                 k, bus.BUSY, bus.DONE, bus.S, bus.COUT, bus.OVF, ts[k], tc[k], tv[k]);
      end
      tick();
      vectors++;
      if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0 || bus.S !== ts[k]) begin
        miscompares++;
        $display("FAIL arith%0d_done_pulse: got done=%b busy=%b s=%h, want 0 0 %h",
                 k, bus.DONE, bus.BUSY, bus.S, ts[k]);
      end
      prev_s = ts[k];
    end
  endtask

  task automatic test_protocol();
    launch(8'h3C, 8'h05, 1'b0);
    for (int i = 1; i < WIDTH; i++) begin
      if (i == 2) begin
        bus.START = 1'b1;
        bus.A     = 8'h11;
        bus.B     = 8'hAA;
        bus.SUB   = 1'b1;
      end
      if (i == 4) bus.START = 1'b0;
      tick();
    end
    tick();
    vectors++;
    if (bus.DONE !== 1'b1 || bus.S !== 8'h41 || bus.COUT !== 1'b0 || bus.OVF !== 1'b0) begin
      miscompares++;
      $display("FAIL proto_ignore_start: got done=%b s=%h cout=%b ovf=%b, want 1 41 0 0",
               bus.DONE, bus.S, bus.COUT, bus.OVF);
    end
    // Request raised during FIN: it must be ignored there and taken in the following IDLE cycle.
    bus.START = 1'b1;
    bus.A     = 8'h02;
    bus.B     = 8'h03;
    bus.SUB   = 1'b0;
    tick();
    vectors++;
    if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.S !== 8'h41) begin
      miscompares++;
      $display("FAIL proto_fin_ignores_start: got busy=%b done=%b s=%h, want 0 0 41",
               bus.BUSY, bus.DONE, bus.S);
    end
    tick();
    bus.START = 1'b0;
    vectors++;
    if (bus.BUSY !== 1'b1 || bus.S !== 8'h41) begin
      miscompares++;
      $display("FAIL proto_first_idle_accept: got busy=%b s=%h, want 1 41", bus.BUSY, bus.S);
    end
    for (int i = 1; i < WIDTH; i++) tick();
    vectors++;
    if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0 || bus.S !== 8'h41) begin
      miscompares++;
      $display("FAIL proto_hold_prev: got busy=%b done=%b s=%h, want 1 0 41",
               bus.BUSY, bus.DONE, bus.S);
    end
    tick();
    vectors++;
    if (bus.DONE !== 1'b1 || bus.S !== 8'h05 || bus.COUT !== 1'b0 || bus.OVF !== 1'b0) begin
      miscompares++;
      $display("FAIL proto_back_to_back: got done=%b s=%h cout=%b ovf=%b, want 1 05 0 0",
               bus.DONE, bus.S, bus.COUT, bus.OVF);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit saw_done = 1'b0;
    launch(8'h3C, 8'h05, 1'b0);
    for (int i = 1; i <= WIDTH; i++) tick();
    vectors++;
    if (bus.DONE !== 1'b1 || bus.S !== 8'h41) begin
      miscompares++;
      $display("FAIL rstmid_setup: got done=%b s=%h, want 1 41", bus.DONE, bus.S);
    end
    tick();
    launch(8'h10, 8'h10, 1'b0);
    for (int i = 1; i <= 3; i++) tick();
    R = 1'b1;
    tick();
    R = 1'b0;
    vectors++;
    if ({bus.BUSY, bus.DONE, bus.S, bus.COUT, bus.OVF} !== 11'h000) begin
      miscompares++;
      $display("FAIL rstmid_clear: got busy=%b done=%b s=%h cout=%b ovf=%b, want all 0",
               bus.BUSY, bus.DONE, bus.S, bus.COUT, bus.OVF);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done) begin
      miscompares++;
      $display("FAIL rstmid_no_done: got activity after reset, want none");
    end
    launch(8'h02, 8'h03, 1'b0);
    for (int i = 1; i <= WIDTH; i++) tick();
    vectors++;
    if (bus.DONE !== 1'b1 || bus.S !== 8'h05 || bus.COUT !== 1'b0 || bus.OVF !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_recover: got done=%b s=%h cout=%b ovf=%b, want 1 05 0 0",
               bus.DONE, bus.S, bus.COUT, bus.OVF);
    end
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_arith();
    test_protocol();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
